// File: rtl/dff_pipe_stage.sv
// One register stage of the flow-controlled pipe: loads the upstream word when the
// chain says it may advance, otherwise holds; rst/clr force the empty reset state.
module dff_pipe_stage #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v_out <= 1'b0;
      d_out <= RST_VAL;
    end else if (adv) begin
      v_out <= v_in;
      d_out <= d_in;
    end
  end

endmodule

// File: rtl/dff_pipe_sync.sv
// DEPTH-stage retiming pipe with valid/ready back-pressure, bubble collapsing,
// synchronous flush, occupancy count and an inverted copy of the output word.
module dff_pipe_sync #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_data_n,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            adv;
  logic                        adv_run;
  logic                        accept;
  logic                        consume;

  // A stage may move if it or any stage downstream of it is empty, or the consumer pops.
  always_comb begin
    adv     = '0;
    adv_run = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_run = adv_run | ~v[i];
      adv[i]  = adv_run;
    end
  end

  assign in_ready = adv[0] & ~rst & ~flush;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    if (i == 0) begin : g_head
      assign v_in = accept;
      assign d_in = in_data;
    end else begin : g_body
      assign v_in = v[i-1];
      assign d_in = d[i-1];
    end
    dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .adv   (adv[i]),
      .v_in  (v_in),
      .d_in  (d_in),
      .v_out (v[i]),
      .d_out (d[i])
    );
  end

  assign out_valid  = v[DEPTH-1];
  assign out_data   = d[DEPTH-1];
  assign out_data_n = ~out_data;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (accept && !consume) begin
      count <= count + 1'b1;
    end else if (consume && !accept) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_dff_pipe_sync.sv
// Directed and randomized checks of dff_pipe_sync (WIDTH=8, DEPTH=4, RST_VAL=A5).
module tb_dff_pipe_sync;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_data_n;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  dff_pipe_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_data_n (out_data_n),
    .out_ready  (out_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_word;
  logic             acc;
  logic             pop;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'hA5);
    chk("rst_out_data_n", 32'(out_data_n), 32'h5A);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // latency and back-to-back throughput
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    #1 chk("lat_in_ready", 32'(in_ready), 32'd1);
    step(); in_data = 8'h02;
    step(); in_data = 8'h03;
    step(); in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    step();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_d01", 32'(out_data), 32'h01);
    chk("lat_d01_n", 32'(out_data_n), 32'hFE);
    chk("lat_count3", 32'(count), 32'd3);
    step(); chk("lat_d02", 32'(out_data), 32'h02);
    step(); chk("lat_d03", 32'(out_data), 32'h03);
    step();
    chk("lat_empty", 32'(out_valid), 32'd0);
    chk("lat_count0", 32'(count), 32'd0);

    // fill to full, then simultaneous push/pop
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h10 + 8'(k);
      step();
    end
    in_data = 8'h14;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_head", 32'(out_data), 32'h10);
    step();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_head", 32'(out_data), 32'h10);
    out_ready = 1'b1;
    #1 chk("pushpop_in_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    chk("pushpop_count", 32'(count), 32'd4);
    chk("pushpop_d11", 32'(out_data), 32'h11);
    step(); chk("drain_d12", 32'(out_data), 32'h12); chk("drain_c3", 32'(count), 32'd3);
    step(); chk("drain_d13", 32'(out_data), 32'h13); chk("drain_c2", 32'(count), 32'd2);
    step(); chk("drain_d14", 32'(out_data), 32'h14); chk("drain_c1", 32'(count), 32'd1);
    step(); chk("drain_empty", 32'(out_valid), 32'd0); chk("drain_c0", 32'(count), 32'd0);

    // bubble collapse behind a stalled output
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h20;
    step(); in_valid = 1'b0;
    step(); step();
    in_valid = 1'b1; in_data = 8'h21;
    step(); in_valid = 1'b0;
    chk("bub_valid", 32'(out_valid), 32'd1);
    chk("bub_d20", 32'(out_data), 32'h20);
    chk("bub_count", 32'(count), 32'd2);
    step(); step();
    chk("bub_hold", 32'(out_data), 32'h20);
    out_ready = 1'b1;
    step(); chk("bub_d21", 32'(out_data), 32'h21); chk("bub_c1", 32'(count), 32'd1);
    step(); chk("bub_empty", 32'(out_valid), 32'd0); chk("bub_c0", 32'(count), 32'd0);

    // flush with held data and an offered word
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h30 + 8'(k);
      step();
    end
    chk("fl_count3", 32'(count), 32'd3);
    flush = 1'b1; in_data = 8'h33;
    #1 chk("fl_in_ready", 32'(in_ready), 32'd0);
    step(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_count0", 32'(count), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fl_no_ghost", 32'(out_valid), 32'd0);
    end

    // reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40;
    step(); in_data = 8'h41;
    step(); in_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; out_ready = 1'b1;
    chk("mrst_count", 32'(count), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mrst_no_ghost", 32'(out_valid), 32'd0);
    end

    // random traffic against a scoreboard
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      #1;
      acc = in_valid & in_ready;
      pop = out_valid & out_ready;
      if (pop) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_pop", 32'(pop), 32'd0);
        end else begin
          exp_word = q.pop_front();
          chk("rnd_order", 32'(out_data), 32'(exp_word));
        end
      end
      if (acc) q.push_back(in_data);
      step();
      chk("rnd_count", 32'(count), 32'(q.size()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
